dmem_arbiter: RTL and testbench

Data-memory port arbiter between the CPU pipeline MEM stage and the matrix accelerator. It grants the single-port synchronous data memory to one requester per cycle and drives the memory command. It routes the one-cycle-late read data back to whichever requester issued the read. It bounds accelerator lock bursts so the CPU pipeline cannot stall indefinitely.

---
 rtl/dmem_arbiter_if.sv | 64 ++++++
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the CPU request port, the accelerator request port and the
// single-port data memory command/response port used by dmem_arbiter.
//
// Modports:
//   slave  - the arbiter's view: requests in, grants/responses out,
//            memory command out, memory read data in
//   master - the opposite view, used by requesters, the memory and benches
//
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request
//   cpu_gnt/cpu_rvalid/cpu_rdata       CPU grant and read response
//   acc_req/acc_we/acc_addr/acc_wdata  accelerator request
//   acc_lock                           accelerator asks for back-to-back ownership
//   acc_gnt/acc_rvalid/acc_rdata       accelerator grant and read response
//   mem_en/mem_we/mem_addr/mem_wdata   memory command
//   mem_rdata                          memory read data (one cycle after read)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              acc_req;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_lock;
  logic              acc_gnt;
  logic              acc_rvalid;
  logic [DATA_W-1:0] acc_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  acc_req, acc_we, acc_addr, acc_wdata, acc_lock,
    output acc_gnt, acc_rvalid, acc_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output acc_req, acc_we, acc_addr, acc_wdata, acc_lock,
    input  acc_gnt, acc_rvalid, acc_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port synchronous data memory between the CPU MEM stage
// and the matrix accelerator. One requester is granted per cycle, the memory
// command is muxed from the winner, and the read data that comes back one
// cycle later is routed to whichever requester issued that read. Accelerator
// lock bursts are bounded to MAX_LOCK contended grants so the CPU cannot be
// starved.
//
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   bus    - dmem_arbiter_if.slave (CPU port, accelerator port, memory port)
//
// Parameters:
//   ADDR_W   - byte-address width (must match the interface)
//   DATA_W   - data width (must match the interface)
//   MAX_LOCK - max consecutive contended accelerator grants under lock (1..255)
//
// Build option:
//   DMEM_ARB_RR_EN - when defined, contended cycles without an active lock
//                    are arbitrated round robin; otherwise the CPU has fixed
//                    priority over the accelerator.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input logic          clk,
  input logic          reset,
  dmem_arbiter_if.slave bus
);

  // Read-response owner encoding
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_ACC  = 2'd2;

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  logic              cpu_gnt_c;
  logic              acc_gnt_c;
  logic              acc_gnt_q;
  logic [7:0]        lock_cnt;
  logic [1:0]        rd_owner;
  logic              lock_hold;
  logic              lock_spent;
  logic              contended;
  logic              cpu_rvalid_c;
  logic              acc_rvalid_c;
  logic              we_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

`ifdef DMEM_ARB_RR_EN
  // 0 = CPU preferred on the next contended cycle, 1 = accelerator preferred
  logic rr_ptr;
`endif

  assign contended  = bus.cpu_req && bus.acc_req;
  // The accelerator keeps ownership only if it won last cycle and the
  // burst budget is not yet used up.
  assign lock_hold  = acc_gnt_q && bus.acc_lock && bus.acc_req
                      && (lock_cnt < MAX_LOCK_C);
  assign lock_spent = (lock_cnt >= MAX_LOCK_C);

  // Grant decision: lock first, then burst-budget override, then the
  // build-selected priority. Reset forces everything off.
  always_comb begin
    cpu_gnt_c = 1'b0;
    acc_gnt_c = 1'b0;
    if (!reset) begin
      if (contended) begin
        if (lock_hold) begin
          acc_gnt_c = 1'b1;
        end else if (lock_spent) begin
          cpu_gnt_c = 1'b1;
        end else begin
`ifdef DMEM_ARB_RR_EN
          if (rr_ptr) acc_gnt_c = 1'b1;
          else        cpu_gnt_c = 1'b1;
`else
          cpu_gnt_c = 1'b1;
`endif
        end
      end else if (bus.cpu_req) begin
        cpu_gnt_c = 1'b1;
      end else if (bus.acc_req) begin
        acc_gnt_c = 1'b1;
      end
    end
  end

  // Memory command mux; idle cycles drive all zeros.
  always_comb begin
    we_mux    = 1'b0;
    addr_mux  = '0;
    wdata_mux = '0;
    if (cpu_gnt_c) begin
      we_mux    = bus.cpu_we;
      addr_mux  = bus.cpu_addr;
      wdata_mux = bus.cpu_wdata;
    end else if (acc_gnt_c) begin
      we_mux    = bus.acc_we;
      addr_mux  = bus.acc_addr;
      wdata_mux = bus.acc_wdata;
    end
  end

  // Lock bookkeeping and read-owner tracking. lock_cnt only counts grants
  // that actually kept the CPU waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_gnt_q <= 1'b0;
      lock_cnt  <= 8'd0;
      rd_owner  <= OWN_NONE;
    end else begin
      acc_gnt_q <= acc_gnt_c;

      if (!bus.acc_lock || cpu_gnt_c) begin
        lock_cnt <= 8'd0;
      end else if (acc_gnt_c && bus.cpu_req && !lock_spent) begin
        lock_cnt <= lock_cnt + 8'd1;
      end

      if (cpu_gnt_c && !bus.cpu_we) begin
        rd_owner <= OWN_CPU;
      end else if (acc_gnt_c && !bus.acc_we) begin
        rd_owner <= OWN_ACC;
      end else begin
        rd_owner <= OWN_NONE;
      end
    end
  end

`ifdef DMEM_ARB_RR_EN
  // After a contended grant the pointer prefers the requester that lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (contended && (cpu_gnt_c || acc_gnt_c)) begin
      rr_ptr <= cpu_gnt_c;
    end
  end
`endif

  // Responses are gated by reset so an outstanding read is dropped.
  assign cpu_rvalid_c = !reset && (rd_owner == OWN_CPU);
  assign acc_rvalid_c = !reset && (rd_owner == OWN_ACC);

  assign bus.cpu_gnt    = cpu_gnt_c;
  assign bus.acc_gnt    = acc_gnt_c;
  assign bus.cpu_rvalid = cpu_rvalid_c;
  assign bus.acc_rvalid = acc_rvalid_c;
  assign bus.cpu_rdata  = cpu_rvalid_c ? bus.mem_rdata : '0;
  assign bus.acc_rdata  = acc_rvalid_c ? bus.mem_rdata : '0;

  assign bus.mem_en    = cpu_gnt_c || acc_gnt_c;
  assign bus.mem_we    = we_mux;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with MAX_LOCK=4 and a small synchronous
// memory model. A vector table covers the uncontended path, pipelined
// interleaved reads and plain contention; hand-written sequences cover the
// lock bound, lock release and reset during an outstanding read.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory, read data valid the cycle after the read
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end
  end

  typedef struct {
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        acc_req;
    logic        acc_we;
    logic        acc_lock;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        exp_cpu_gnt;
    logic        exp_acc_gnt;
    logic        exp_mem_we;
    logic [31:0] exp_mem_addr;
    logic        exp_cpu_rvalid;
    logic [31:0] exp_cpu_rdata;
    logic        exp_acc_rvalid;
    logic [31:0] exp_acc_rdata;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.cpu_req   = v.cpu_req;
    bus.cpu_we    = v.cpu_we;
    bus.cpu_addr  = v.cpu_addr;
    bus.cpu_wdata = v.cpu_wdata;
    bus.acc_req   = v.acc_req;
    bus.acc_we    = v.acc_we;
    bus.acc_lock  = v.acc_lock;
    bus.acc_addr  = v.acc_addr;
    bus.acc_wdata = v.acc_wdata;
  endtask

  task automatic driveIdle();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.acc_req = 0; bus.acc_we = 0; bus.acc_lock = 0; bus.acc_addr = 0; bus.acc_wdata = 0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    driveIdle();
    nextCycle();
    reset = 1'b0;
  endtask

  // One cycle of CPU read at 0x20 / accelerator read at 0x24 with grant checks
  task automatic lockCycle(input logic cr, input logic ar, input logic al,
                           input logic ec, input logic ea, input string name);
    bus.cpu_req = cr; bus.cpu_we = 0; bus.cpu_addr = 32'h20;
    bus.acc_req = ar; bus.acc_we = 0; bus.acc_addr = 32'h24; bus.acc_lock = al;
    @(negedge clk);
    checkOutput({name, ".cpu_gnt"}, {31'd0, bus.cpu_gnt}, {31'd0, ec});
    checkOutput({name, ".acc_gnt"}, {31'd0, bus.acc_gnt}, {31'd0, ea});
    nextCycle();
  endtask

  initial begin
    vec_t v;
    logic [31:0] exp_wdata;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8] = 32'hA5A50020;
    mem[9] = 32'h5A5A0024;
    bus.mem_rdata = 32'h0;

    // req we addr wdata | req we lock addr wdata | cgnt agnt mwe maddr | crv crd | arv ard
    vecs[0] = '{1,1,32'h10,32'h12345678, 0,0,0,32'h0,32'h0, 1,0,1,32'h10, 0,32'h0, 0,32'h0};
    vecs[1] = '{1,0,32'h10,32'h0,        0,0,0,32'h0,32'h0, 1,0,0,32'h10, 0,32'h0, 0,32'h0};
    vecs[2] = '{0,0,32'h0,32'h0,         0,0,0,32'h0,32'h0, 0,0,0,32'h0,  1,32'h12345678, 0,32'h0};
    vecs[3] = '{1,0,32'h20,32'h0,        0,0,0,32'h0,32'h0, 1,0,0,32'h20, 0,32'h0, 0,32'h0};
    vecs[4] = '{0,0,32'h0,32'h0,         1,0,0,32'h24,32'h0, 0,1,0,32'h24, 1,32'hA5A50020, 0,32'h0};
    vecs[5] = '{0,0,32'h0,32'h0,         0,0,0,32'h0,32'h0, 0,0,0,32'h0,  0,32'h0, 1,32'h5A5A0024};
`ifdef DMEM_ARB_RR_EN
    vecs[6]  = '{1,0,32'h20,32'h0, 1,0,0,32'h24,32'h0, 1,0,0,32'h20, 0,32'h0, 0,32'h0};
    vecs[7]  = '{1,0,32'h20,32'h0, 1,0,0,32'h24,32'h0, 0,1,0,32'h24, 1,32'hA5A50020, 0,32'h0};
    vecs[8]  = '{1,0,32'h20,32'h0, 1,0,0,32'h24,32'h0, 1,0,0,32'h20, 0,32'h0, 1,32'h5A5A0024};
    vecs[9]  = '{1,0,32'h20,32'h0, 1,0,0,32'h24,32'h0, 0,1,0,32'h24, 1,32'hA5A50020, 0,32'h0};
    vecs[10] = '{0,0,32'h0,32'h0,  0,0,0,32'h0,32'h0,  0,0,0,32'h0,  0,32'h0, 1,32'h5A5A0024};
`else
    vecs[6]  = '{1,0,32'h20,32'h0, 1,0,0,32'h24,32'h0, 1,0,0,32'h20, 0,32'h0, 0,32'h0};
    vecs[7]  = '{1,0,32'h20,32'h0, 1,0,0,32'h24,32'h0, 1,0,0,32'h20, 1,32'hA5A50020, 0,32'h0};
    vecs[8]  = '{1,0,32'h20,32'h0, 1,0,0,32'h24,32'h0, 1,0,0,32'h20, 1,32'hA5A50020, 0,32'h0};
    vecs[9]  = '{1,0,32'h20,32'h0, 1,0,0,32'h24,32'h0, 1,0,0,32'h20, 1,32'hA5A50020, 0,32'h0};
    vecs[10] = '{0,0,32'h0,32'h0,  0,0,0,32'h0,32'h0,  0,0,0,32'h0,  1,32'hA5A50020, 0,32'h0};
`endif

    // Reset state, with a CPU request present that must be ignored
    reset = 1'b1;
    driveIdle();
    bus.cpu_req = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("rst.cpu_gnt",    {31'd0, bus.cpu_gnt},    32'd0);
    checkOutput("rst.mem_en",     {31'd0, bus.mem_en},     32'd0);
    checkOutput("rst.cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    checkOutput("rst.mem_addr",   bus.mem_addr,            32'd0);
    nextCycle();
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      v = vecs[i];
      applyStimulus(v);
      @(negedge clk);
      exp_wdata = v.exp_cpu_gnt ? v.cpu_wdata : (v.exp_acc_gnt ? v.acc_wdata : 32'h0);
      checkOutput($sformatf("v%0d.cpu_gnt", i),    {31'd0, bus.cpu_gnt},    {31'd0, v.exp_cpu_gnt});
      checkOutput($sformatf("v%0d.acc_gnt", i),    {31'd0, bus.acc_gnt},    {31'd0, v.exp_acc_gnt});
      checkOutput($sformatf("v%0d.mem_en", i),     {31'd0, bus.mem_en},     {31'd0, v.exp_cpu_gnt | v.exp_acc_gnt});
      checkOutput($sformatf("v%0d.mem_we", i),     {31'd0, bus.mem_we},     {31'd0, v.exp_mem_we});
      checkOutput($sformatf("v%0d.mem_addr", i),   bus.mem_addr,            v.exp_mem_addr);
      checkOutput($sformatf("v%0d.mem_wdata", i),  bus.mem_wdata,           exp_wdata);
      checkOutput($sformatf("v%0d.cpu_rvalid", i), {31'd0, bus.cpu_rvalid}, {31'd0, v.exp_cpu_rvalid});
      checkOutput($sformatf("v%0d.cpu_rdata", i),  bus.cpu_rdata,           v.exp_cpu_rdata);
      checkOutput($sformatf("v%0d.acc_rvalid", i), {31'd0, bus.acc_rvalid}, {31'd0, v.exp_acc_rvalid});
      checkOutput($sformatf("v%0d.acc_rdata", i),  bus.acc_rdata,           v.exp_acc_rdata);
      nextCycle();
    end

    // Lock bound: 4 contended accelerator grants, then the CPU, then resume
    doReset();
    lockCycle(0, 1, 1, 0, 1, "lk0");
    for (int i = 1; i <= 4; i++) lockCycle(1, 1, 1, 0, 1, $sformatf("lk%0d", i));
    lockCycle(1, 1, 1, 1, 0, "lk5");
    checkOutput("lk5.lock_cnt", {24'd0, dut.lock_cnt}, 32'd0);
    lockCycle(0, 1, 1, 0, 1, "lk6");
    lockCycle(1, 1, 1, 0, 1, "lk7");

    // Lock release mid-burst
    doReset();
    lockCycle(0, 1, 1, 0, 1, "rl0");
    lockCycle(1, 1, 1, 0, 1, "rl1");
    checkOutput("rl1.lock_cnt", {24'd0, dut.lock_cnt}, 32'd1);
    lockCycle(1, 1, 0, 1, 0, "rl2");
    checkOutput("rl2.lock_cnt", {24'd0, dut.lock_cnt}, 32'd0);

    // Reset while a CPU read is outstanding
    doReset();
    lockCycle(1, 0, 0, 1, 0, "rr0");
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rr1.cpu_gnt",    {31'd0, bus.cpu_gnt},    32'd0);
    checkOutput("rr1.acc_gnt",    {31'd0, bus.acc_gnt},    32'd0);
    checkOutput("rr1.cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    checkOutput("rr1.cpu_rdata",  bus.cpu_rdata,           32'd0);
    checkOutput("rr1.mem_en",     {31'd0, bus.mem_en},     32'd0);
    checkOutput("rr1.mem_we",     {31'd0, bus.mem_we},     32'd0);
    checkOutput("rr1.mem_addr",   bus.mem_addr,            32'd0);
    checkOutput("rr1.mem_wdata",  bus.mem_wdata,           32'd0);
    nextCycle();
    reset = 1'b0;
    driveIdle();
    @(negedge clk);
    checkOutput("rr2.cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    checkOutput("rr2.cpu_rdata",  bus.cpu_rdata,           32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("rr3.cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
